// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register; owns the PC and the imem req/ack port.
// Latency: zero-wait ack reaches IF/ID on the next edge, so back-to-back fetches give 1 instr/cycle.
// Backpressure: Stall freezes PC and IF/ID, and an acked word is parked in a one-entry buffer.
// Optional build macro FETCH_PERF_CNT_EN adds the stall_cycles / bubble_cycles counters.
module fetch_stage #(
  parameter int            WL       = 32,
  parameter logic [WL-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Stall,
  input  logic          PCSrcD,
  input  logic [WL-1:0] PCBranchD,
  output logic          imem_req,
  output logic [WL-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [WL-1:0] imem_rdata,
  output logic [WL-1:0] InstrD,
  output logic [WL-1:0] PCPlus4D,
  output logic          ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   bubble_cycles
`endif
);

  localparam logic [WL-1:0] FOUR = WL'(4);
  localparam logic [WL-1:0] LOW2 = WL'(3);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [WL-1:0] pc_q, pc_d;
  logic [WL-1:0] stale_q, stale_d;   // address of the abandoned request while draining
  logic [WL-1:0] buf_q, buf_d;       // instruction acked while stalled
  logic [WL-1:0] if_instr_q, if_instr_d;
  logic [WL-1:0] if_pcp4_q, if_pcp4_d;
  logic          if_valid_q, if_valid_d;

  logic          redirect;
  logic          avail;
  logic          bubble_load;
  logic [WL-1:0] target;
  logic [WL-1:0] pc_plus4;
  logic [WL-1:0] next_instr;

  // Memory port is decoded from registered state only, never from imem_ack.
  always_comb begin
    imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr = (state_q == DRAIN) ? stale_q : pc_q;
  end

  // Next-state, PC and IF/ID update; priority is Stall > redirect > normal fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stale_d     = stale_q;
    buf_d       = buf_q;
    if_instr_d  = if_instr_q;
    if_pcp4_d   = if_pcp4_q;
    if_valid_d  = if_valid_q;
    bubble_load = 1'b0;

    redirect   = PCSrcD & ~Stall;
    avail      = ((state_q == FETCH) && imem_ack) || (state_q == HOLD);
    target     = PCBranchD & ~LOW2;
    pc_plus4   = pc_q + FOUR;
    next_instr = (state_q == HOLD) ? buf_q : imem_rdata;

    if (Stall) begin
      case (state_q)
        BOOT:  state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD:  state_d = HOLD;
        DRAIN: if (imem_ack) state_d = FETCH;
        default: state_d = BOOT;
      endcase
    end else if (redirect) begin
      pc_d        = target;
      bubble_load = 1'b1;
      case (state_q)
        FETCH: begin
          if (!imem_ack) begin
            // The in-flight request must finish at its original address.
            stale_d = pc_q;
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end
        DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else if (avail) begin
      if_instr_d = next_instr;
      if_pcp4_d  = pc_plus4;
      if_valid_d = 1'b1;
      pc_d       = pc_plus4;
      state_d    = FETCH;
    end else begin
      bubble_load = 1'b1;
      if ((state_q == BOOT) || ((state_q == DRAIN) && imem_ack)) begin
        state_d = FETCH;
      end
    end

    if (bubble_load) begin
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end
  end

  // State, PC, buffer and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      stale_q    <= '0;
      buf_q      <= '0;
      if_instr_q <= '0;
      if_pcp4_q  <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stale_q    <= stale_d;
      buf_q      <= buf_d;
      if_instr_q <= if_instr_d;
      if_pcp4_q  <= if_pcp4_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign InstrD   = if_instr_q;
  assign PCPlus4D = if_pcp4_q;
  assign ValidD   = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating event counters for stall cycles and bubble loads.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bubble_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign bubble_cycles = bubble_cnt_q;
`endif

endmodule
